// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bus controller: region codes,
// register offsets, FSM state encoding and timer CTRL bit positions.
package mio_pkg;

  localparam logic [3:0] REG_RAM  = 4'h0;
  localparam logic [3:0] REG_GPIO = 4'hE;
  localparam logic [3:0] REG_TMR  = 4'hF;

  localparam logic [27:0] OFF_LED   = 28'h000_0000;
  localparam logic [27:0] OFF_SW    = 28'h000_0004;
  localparam logic [27:0] OFF_COUNT = 28'h000_0000;
  localparam logic [27:0] OFF_CMP   = 28'h000_0004;
  localparam logic [27:0] OFF_CTRL  = 28'h000_0008;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_PEND = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

endpackage

// File: rtl/mio_timer.sv
// Compare timer: free-running COUNT that wraps on CMP match and latches a
// pending flag (INT). Only instantiated when MIO_TIMER_EN is defined.
module mio_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [27:0] off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        int_o
);
  import mio_pkg::*;

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;
  logic        match;

  assign match = en_q && (count_q == cmp_q);

  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    if (en_q) count_d = match ? '0 : count_q + 32'd1;
    if (wr_i && off_i == OFF_COUNT) count_d = wdata_i;
    if (wr_i && off_i == OFF_CMP)   cmp_d   = wdata_i;
    if (wr_i && off_i == OFF_CTRL) begin
      en_d = wdata_i[CTRL_EN];
      if (wdata_i[CTRL_PEND]) pend_d = 1'b0;
    end
    // a match in the same cycle as a clear keeps the flag set
    if (match) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      cmp_q   <= '1;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_i)
      OFF_COUNT: rdata_o = count_q;
      OFF_CMP:   rdata_o = cmp_q;
      OFF_CTRL:  rdata_o = {30'b0, pend_q, en_q};
      default:   rdata_o = '0;
    endcase
  end

  assign int_o = pend_q;

endmodule

// File: rtl/mio_bus_ctrl.sv
// Bus controller between the multicycle core and RAM / GPIO / timer.
// Define MIO_TIMER_EN to build the compare timer; otherwise INT is tied low.
module mio_bus_ctrl #(
  parameter int unsigned RAM_AW      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic              INT,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
);
  import mio_pkg::*;

  state_e            state_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [15:0]       wait_q;
  logic [31:0]       data_q;
  logic              ready_q;
  logic              ram_we_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [31:0]       ram_din_q;
  logic [15:0]       led_q;

  logic [3:0]  region;
  logic [27:0] off;
  logic [31:0] rd_mux;
  logic [31:0] tmr_rdata;
  logic        tmr_int;

  assign region = addr_q[31:28];
  assign off    = addr_q[27:0];

`ifdef MIO_TIMER_EN
  logic tmr_wr;
  assign tmr_wr = (state_q == DONE) && we_q && (region == REG_TMR);

  mio_timer u_timer (
    .clk_i   (clk),
    .rst_i   (reset),
    .wr_i    (tmr_wr),
    .off_i   (off),
    .wdata_i (wdata_q),
    .rdata_o (tmr_rdata),
    .int_o   (tmr_int)
  );
`else
  assign tmr_rdata = '0;
  assign tmr_int   = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (region)
      REG_RAM:  rd_mux = ram_dout;
      REG_GPIO: begin
        if (off == OFF_LED)     rd_mux = {16'b0, led_q};
        else if (off == OFF_SW) rd_mux = {16'b0, sw_in};
      end
      REG_TMR:  rd_mux = tmr_rdata;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      wait_q     <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      led_q      <= '0;
    end else begin
      ready_q  <= 1'b0;
      ram_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (CPU_MIO) begin
            addr_q     <= Addr_out;
            wdata_q    <= Data_out;
            we_q       <= mem_w;
            wait_q     <= 16'(WAIT_CYCLES);
            ram_addr_q <= Addr_out[RAM_AW+1:2];
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          wait_q <= wait_q - 16'd1;
          if (wait_q == 16'd1) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            if (we_q && region == REG_RAM) begin
              ram_we_q  <= 1'b1;
              ram_din_q <= wdata_q;
            end
          end
        end
        DONE: begin
          if (!we_q) data_q <= rd_mux;
          if (we_q && region == REG_GPIO && off == OFF_LED) led_q <= wdata_q[15:0];
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM data only arrives during DONE, so the read path is bypassed onto
  // Data_in for that cycle and held in data_q from then on.
  assign Data_in   = (state_q == DONE && !we_q) ? rd_mux : data_q;
  assign MIO_ready = ready_q;
  assign INT       = tmr_int;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign led_out   = led_q;

endmodule
